// File: rtl/shaper_peak_detector.sv
// Pulse peak detector for the shaped sample stream: tracks each pulse above threshold,
// records its first maximum, timestamp and width, and offers one event per pulse downstream.
module shaper_peak_detector #(
  parameter int SIZE_SHAPER_DATA = 16,
  parameter int SIZE_TIMESTAMP   = 32,
  parameter int SIZE_WIDTH       = 8,
  parameter int MIN_WIDTH        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_SHAPER_DATA-1:0] input_data,
  input  logic                        enable,
  input  logic [SIZE_SHAPER_DATA-1:0] threshold,
  input  logic [SIZE_SHAPER_DATA-1:0] hysteresis,
  output logic [SIZE_SHAPER_DATA-1:0] peak_amplitude,
  output logic [SIZE_TIMESTAMP-1:0]   peak_time,
  output logic [SIZE_WIDTH-1:0]       peak_width,
  output logic                        peak_valid,
  input  logic                        peak_ready,
  output logic [7:0]                  drop_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RISE = 1'b1
  } state_t;

  function automatic logic [SIZE_SHAPER_DATA-1:0] sat_sub(
    input logic [SIZE_SHAPER_DATA-1:0] a,
    input logic [SIZE_SHAPER_DATA-1:0] b
  );
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [SIZE_WIDTH-1:0] sat_inc_width(input logic [SIZE_WIDTH-1:0] w);
    return (&w) ? w : (w + 1'b1);
  endfunction

  function automatic logic [7:0] sat_inc_drop(input logic [7:0] d);
    return (&d) ? d : (d + 1'b1);
  endfunction

  state_t                      state, state_nxt;
  logic [SIZE_TIMESTAMP-1:0]   timestamp;
  logic [SIZE_SHAPER_DATA-1:0] end_level;
  logic [SIZE_SHAPER_DATA-1:0] max_amp;
  logic [SIZE_TIMESTAMP-1:0]   max_time;
  logic [SIZE_WIDTH-1:0]       width;
  logic                        pulse_start, pulse_end, pulse_grow, max_upd;
  logic                        width_ok;

  logic                        vld_p1;
  logic [SIZE_SHAPER_DATA-1:0] evt_amp_p1;
  logic [SIZE_TIMESTAMP-1:0]   evt_time_p1;
  logic [SIZE_WIDTH-1:0]       evt_width_p1;

  assign end_level = sat_sub(threshold, hysteresis);
  assign width_ok  = (width >= SIZE_WIDTH'(MIN_WIDTH));

  always_comb begin
    state_nxt   = state;
    pulse_start = 1'b0;
    pulse_end   = 1'b0;
    pulse_grow  = 1'b0;
    max_upd     = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (input_data > threshold) begin
            state_nxt   = RISE;
            pulse_start = 1'b1;
          end
        end
        RISE: begin
          // The ending sample closes the pulse and is neither counted nor a re-arm.
          if (input_data <= end_level) begin
            state_nxt = IDLE;
            pulse_end = 1'b1;
          end else begin
            pulse_grow = 1'b1;
            max_upd    = (input_data > max_amp);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timestamp <= '0;
    end else begin
      timestamp <= timestamp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_amp  <= '0;
      max_time <= '0;
      width    <= '0;
    end else if (pulse_start) begin
      max_amp  <= input_data;
      max_time <= timestamp;
      width    <= SIZE_WIDTH'(1);
    end else if (pulse_grow) begin
      width <= sat_inc_width(width);
      if (max_upd) begin
        max_amp  <= input_data;
        max_time <= timestamp;
      end
    end
  end

  // Stage p1: finished pulse staged for one clock before reaching the event register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      evt_amp_p1   <= '0;
      evt_time_p1  <= '0;
      evt_width_p1 <= '0;
    end else begin
      vld_p1 <= pulse_end && width_ok;
      if (pulse_end) begin
        evt_amp_p1   <= max_amp;
        evt_time_p1  <= max_time;
        evt_width_p1 <= width;
      end
    end
  end

  // Stage p2: single-entry event register with valid/ready handoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_width     <= '0;
      drop_count     <= '0;
    end else if (vld_p1) begin
      if (!peak_valid || peak_ready) begin
        peak_valid     <= 1'b1;
        peak_amplitude <= evt_amp_p1;
        peak_time      <= evt_time_p1;
        peak_width     <= evt_width_p1;
      end else begin
        drop_count <= sat_inc_drop(drop_count);
      end
    end else if (peak_valid && peak_ready) begin
      peak_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shaper_peak_detector.sv
// Bench for shaper_peak_detector: table vectors, directed corner sequences and a random run
// checked against a pulse-level reference model.
module tb_shaper_peak_detector;

  logic        clk;
  logic        reset;
  logic [15:0] input_data;
  logic        enable;
  logic [15:0] threshold;
  logic [15:0] hysteresis;
  logic [15:0] peak_amplitude;
  logic [31:0] peak_time;
  logic [7:0]  peak_width;
  logic        peak_valid;
  logic        peak_ready;
  logic [7:0]  drop_count;

  shaper_peak_detector #(
    .SIZE_SHAPER_DATA(16),
    .SIZE_TIMESTAMP(32),
    .SIZE_WIDTH(8),
    .MIN_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_data(input_data),
    .enable(enable),
    .threshold(threshold),
    .hysteresis(hysteresis),
    .peak_amplitude(peak_amplitude),
    .peak_time(peak_time),
    .peak_width(peak_width),
    .peak_valid(peak_valid),
    .peak_ready(peak_ready),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pulse kept as a list of (sample, timestamp), summarised when it ends.
  typedef struct {
    logic [15:0] d;
    logic [31:0] t;
  } samp_t;

  samp_t       pq[$];
  logic [31:0] m_ts;
  bit          m_in;
  bit          pend_v;
  logic [15:0] pend_a;
  logic [31:0] pend_t;
  logic [7:0]  pend_w;
  bit          o_v;
  logic [15:0] o_a;
  logic [31:0] o_t;
  logic [7:0]  o_w;
  logic [7:0]  o_d;

  function automatic void model_reset();
    pq.delete();
    m_ts = '0; m_in = 0; pend_v = 0;
    pend_a = '0; pend_t = '0; pend_w = '0;
    o_v = 0; o_a = '0; o_t = '0; o_w = '0; o_d = '0;
  endfunction

  function automatic void model_update();
    int unsigned end_lvl;
    int unsigned w;
    logic [15:0] best;
    logic [31:0] best_t;
    if (pend_v) begin
      if (!o_v || peak_ready) begin
        o_v = 1; o_a = pend_a; o_t = pend_t; o_w = pend_w;
      end else if (o_d != 8'd255) begin
        o_d = o_d + 8'd1;
      end
    end else if (o_v && peak_ready) begin
      o_v = 0;
    end
    pend_v = 0;
    if (enable) begin
      end_lvl = (threshold > hysteresis) ? int'(threshold) - int'(hysteresis) : 0;
      if (!m_in) begin
        if (input_data > threshold) begin
          m_in = 1;
          pq.delete();
          pq.push_back('{d: input_data, t: m_ts});
        end
      end else if (int'(input_data) <= int'(end_lvl)) begin
        m_in = 0;
        w = (pq.size() > 255) ? 255 : pq.size();
        best = pq[0].d;
        best_t = pq[0].t;
        for (int i = 1; i < pq.size(); i++) begin
          if (pq[i].d > best) begin
            best = pq[i].d;
            best_t = pq[i].t;
          end
        end
        if (w >= 2) begin
          pend_v = 1; pend_a = best; pend_t = best_t; pend_w = 8'(w);
        end
      end else begin
        pq.push_back('{d: input_data, t: m_ts});
      end
    end
    m_ts = m_ts + 32'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("valid", 64'(peak_valid), 64'(o_v));
    check("amplitude", 64'(peak_amplitude), 64'(o_a));
    check("time", 64'(peak_time), 64'(o_t));
    check("width", 64'(peak_width), 64'(o_w));
    check("drop", 64'(drop_count), 64'(o_d));
  endtask

  // Drive at the falling edge, let the rising edge consume, compare at the next falling edge.
  task automatic step(input logic en, input logic [15:0] d, input logic rdy);
    enable = en; input_data = d; peak_ready = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    int thr; int hyst; int en; int d; int rdy;
    int ev; int amp; int toff; int w; int drop;
  } vec_t;

  vec_t        tbl[23];
  logic [31:0] t0;
  logic [7:0]  drop_before;

  initial begin
    //           thr  hyst en  d    rdy  ev amp toff w drop
    tbl[0]  = '{100, 10,  1, 50,  1,   0, 0,   0,  0, 0};
    tbl[1]  = '{100, 10,  1, 120, 1,   0, 0,   0,  0, 0};
    tbl[2]  = '{100, 10,  1, 300, 1,   0, 0,   0,  0, 0};
    tbl[3]  = '{100, 10,  1, 300, 1,   0, 0,   0,  0, 0};
    tbl[4]  = '{100, 10,  1, 250, 1,   0, 0,   0,  0, 0};
    tbl[5]  = '{100, 10,  1, 80,  1,   0, 0,   0,  0, 0};
    tbl[6]  = '{100, 10,  0, 0,   1,   1, 300, 2,  4, 0};
    tbl[7]  = '{100, 10,  0, 0,   1,   0, 0,   0,  0, 0};
    tbl[8]  = '{100, 10,  1, 150, 1,   0, 0,   0,  0, 0};
    tbl[9]  = '{100, 10,  1, 50,  1,   0, 0,   0,  0, 0};
    tbl[10] = '{100, 10,  0, 0,   1,   0, 0,   0,  0, 0};
    tbl[11] = '{100, 20,  1, 110, 1,   0, 0,   0,  0, 0};
    tbl[12] = '{100, 20,  1, 95,  1,   0, 0,   0,  0, 0};
    tbl[13] = '{100, 20,  1, 105, 1,   0, 0,   0,  0, 0};
    tbl[14] = '{100, 20,  1, 79,  1,   0, 0,   0,  0, 0};
    tbl[15] = '{100, 20,  0, 0,   1,   1, 110, 11, 3, 0};
    tbl[16] = '{100, 20,  0, 0,   1,   0, 0,   0,  0, 0};
    tbl[17] = '{100, 200, 1, 150, 1,   0, 0,   0,  0, 0};
    tbl[18] = '{100, 200, 1, 5,   1,   0, 0,   0,  0, 0};
    tbl[19] = '{100, 200, 1, 1,   1,   0, 0,   0,  0, 0};
    tbl[20] = '{100, 200, 1, 0,   1,   0, 0,   0,  0, 0};
    tbl[21] = '{100, 200, 0, 0,   1,   1, 150, 17, 3, 0};
    tbl[22] = '{100, 200, 0, 0,   1,   0, 0,   0,  0, 0};

    reset = 1'b0; enable = 1'b0; input_data = '0; peak_ready = 1'b0;
    threshold = 16'd100; hysteresis = 16'd10;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 64'(peak_valid), 64'd0);
    check("reset_amp", 64'(peak_amplitude), 64'd0);
    check("reset_time", 64'(peak_time), 64'd0);
    check("reset_width", 64'(peak_width), 64'd0);
    check("reset_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;

    // Table: basic pulse, short pulse, hysteresis levels.
    t0 = m_ts;
    for (int i = 0; i < 23; i++) begin
      threshold = 16'(tbl[i].thr); hysteresis = 16'(tbl[i].hyst);
      step(1'(tbl[i].en), 16'(tbl[i].d), 1'(tbl[i].rdy));
      check($sformatf("tbl%0d_valid", i), 64'(peak_valid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_drop", i), 64'(drop_count), 64'(tbl[i].drop));
      if (tbl[i].ev != 0) begin
        check($sformatf("tbl%0d_amp", i), 64'(peak_amplitude), 64'(tbl[i].amp));
        check($sformatf("tbl%0d_time", i), 64'(peak_time), 64'(t0 + 32'(tbl[i].toff)));
        check($sformatf("tbl%0d_width", i), 64'(peak_width), 64'(tbl[i].w));
      end
    end

    // Full event register with ready low: second event dropped, first held.
    threshold = 16'd100; hysteresis = 16'd10;
    step(1, 200, 0); step(1, 300, 0); step(1, 50, 0); step(0, 0, 0);
    check("hold_valid", 64'(peak_valid), 64'd1);
    check("hold_amp", 64'(peak_amplitude), 64'd300);
    step(1, 150, 0); step(1, 160, 0); step(1, 10, 0); step(0, 0, 0);
    check("drop_one", 64'(drop_count), 64'd1);
    check("drop_amp_kept", 64'(peak_amplitude), 64'd300);
    check("drop_width_kept", 64'(peak_width), 64'd2);
    step(0, 0, 1);
    check("read_clears", 64'(peak_valid), 64'd0);
    step(1, 400, 1); step(1, 500, 1); step(1, 0, 1); step(0, 0, 1);
    check("third_valid", 64'(peak_valid), 64'd1);
    check("third_amp", 64'(peak_amplitude), 64'd500);
    step(0, 0, 1);

    // Ready high on the same clock a new event loads: read and load, no drop.
    drop_before = drop_count;
    step(1, 200, 0); step(1, 300, 0); step(1, 50, 0); step(0, 0, 0);
    step(1, 150, 0); step(1, 250, 0); step(1, 50, 0); step(0, 0, 1);
    check("swap_valid", 64'(peak_valid), 64'd1);
    check("swap_amp", 64'(peak_amplitude), 64'd250);
    check("swap_nodrop", 64'(drop_count), 64'(drop_before));
    step(0, 0, 1);

    // Enable low mid-pulse freezes the pulse; larger samples meanwhile are ignored.
    step(1, 200, 1); step(1, 250, 1);
    repeat (5) step(0, 999, 1);
    step(1, 50, 1); step(0, 0, 1);
    check("freeze_amp", 64'(peak_amplitude), 64'd250);
    check("freeze_width", 64'(peak_width), 64'd2);
    step(0, 0, 1);

    // Asynchronous reset mid-pulse discards the pulse.
    step(1, 200, 1); step(1, 300, 1); step(1, 220, 1);
    #2 reset = 1'b0; enable = 1'b0;
    #1;
    model_reset();
    check("areset_valid", 64'(peak_valid), 64'd0);
    check("areset_amp", 64'(peak_amplitude), 64'd0);
    check("areset_time", 64'(peak_time), 64'd0);
    check("areset_width", 64'(peak_width), 64'd0);
    check("areset_drop", 64'(drop_count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1, 50, 1); step(0, 0, 1); step(0, 0, 1);
    check("areset_noevent", 64'(peak_valid), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) threshold = 16'($urandom_range(50, 200));
      if ($urandom_range(0, 99) == 0) hysteresis = 16'($urandom_range(0, 250));
      step(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 300)),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
